// File: rtl/mem_io_pkg.sv
// mem_io_pkg: shared types and helpers for the mem_io_bridge codebase slice.
//   bridge_state_t : access state machine encoding
//   mem_strobe_t   : active-low SRAM strobe bundle {ce, oe, we, ub, lb}
//   STROBE_IDLE    : every strobe deasserted
//   is_io_addr()   : true when an address falls inside the I/O window
package mem_io_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IO     = 3'd1,
        SETUP  = 3'd2,
        ACCESS = 3'd3,
        DONE   = 3'd4
    } bridge_state_t;

    typedef struct packed {
        logic ce;
        logic oe;
        logic we;
        logic ub;
        logic lb;
    } mem_strobe_t;

    localparam mem_strobe_t STROBE_IDLE = '{ce: 1'b1, oe: 1'b1, we: 1'b1, ub: 1'b1, lb: 1'b1};

    // Upper bound is computed in 33 bits so a window that ends at the very top
    // of the address space cannot wrap around to zero.
    function automatic logic is_io_addr(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input int unsigned num_io);
        return (addr >= base) && ({1'b0, addr} < ({1'b0, base} + 33'(num_io)));
    endfunction

endpackage

// File: rtl/mem_io_bridge_if.sv
// mem_io_bridge_if: CPU-side request/response bus of the bridge.
//   Req/We/Addr/Wdata/Be : request, driven by the CPU (master)
//   Rdata/Ack/Busy       : response, driven by the bridge (slave)
interface mem_io_bridge_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic                  Req;
    logic                  We;
    logic [ADDR_W-1:0]     Addr;
    logic [DATA_W-1:0]     Wdata;
    logic [DATA_W/8-1:0]   Be;
    logic [DATA_W-1:0]     Rdata;
    logic                  Ack;
    logic                  Busy;

    modport master (output Req, We, Addr, Wdata, Be, input Rdata, Ack, Busy);
    modport slave  (input Req, We, Addr, Wdata, Be, output Rdata, Ack, Busy);
endinterface

// File: rtl/mem_io_regs.sv
// mem_io_regs: bank of NUM_IO display registers plus the switch read mux.
//   clk, rst   : clock, synchronous active-high reset (clears all displays)
//   wr_en      : write channel sel this cycle
//   sel        : channel index for both write and read
//   wdata, be  : write word and per-byte lane enables
//   switches   : packed input words, channel k at [k*DATA_W +: DATA_W]
//   display    : packed display registers, same layout
//   rd_data    : switch word of channel sel
module mem_io_regs #(
    parameter int DATA_W = 16,
    parameter int NUM_IO = 2,
    parameter int SEL_W  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [SEL_W-1:0]         sel,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [DATA_W/8-1:0]      be,
    input  logic [NUM_IO*DATA_W-1:0] switches,
    output logic [NUM_IO*DATA_W-1:0] display,
    output logic [DATA_W-1:0]        rd_data
);
    localparam int BE_W = DATA_W / 8;

    logic [NUM_IO*DATA_W-1:0] display_q;
    logic [NUM_IO*DATA_W-1:0] display_d;

    always_comb begin
        display_d = display_q;
        if (wr_en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) begin
                    display_d[int'(sel)*DATA_W + b*8 +: 8] = wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            display_q <= '0;
        end else begin
            display_q <= display_d;
        end
    end

    assign display = display_q;
    assign rd_data = switches[int'(sel)*DATA_W +: DATA_W];

endmodule

// File: rtl/mem_io_bridge.sv
// mem_io_bridge: routes each CPU bus cycle either to a window of NUM_IO
// memory-mapped I/O channels or to an SRAM-style memory with WAIT_STATES
// extra access cycles.
//   Clk, Reset        : clock, synchronous active-high reset
//   bus (slave)       : CPU request/response (Req, We, Addr, Wdata, Be, Rdata, Ack, Busy)
//   Switches/Display  : per-channel I/O input words / display registers
//   Mem_Addr/Mem_Dout : memory address and write data, held between accesses
//   Mem_Din           : memory read data
//   Mem_CE/OE/WE/UB/LB: active-low memory strobes
// Build option: define MEM_IO_BYTE_LANE_EN to honour Be on memory byte strobes
// and on I/O display writes; otherwise Be is ignored and full words are used.
// ADDR_W is limited to 32 bits by the window compare.
module mem_io_bridge
    import mem_io_pkg::*;
#(
    parameter int              ADDR_W      = 20,
    parameter int              DATA_W      = 16,
    parameter int              WAIT_STATES = 2,
    parameter int              NUM_IO      = 2,
    parameter logic [ADDR_W-1:0] IO_BASE   = 20'hFFFF0
) (
    input  logic                     Clk,
    input  logic                     Reset,
    mem_io_bridge_if.slave           bus,
    input  logic [NUM_IO*DATA_W-1:0] Switches,
    output logic [NUM_IO*DATA_W-1:0] Display,
    output logic [ADDR_W-1:0]        Mem_Addr,
    output logic [DATA_W-1:0]        Mem_Dout,
    input  logic [DATA_W-1:0]        Mem_Din,
    output logic                     Mem_CE,
    output logic                     Mem_OE,
    output logic                     Mem_WE,
    output logic                     Mem_UB,
    output logic                     Mem_LB
);
    localparam int BE_W  = DATA_W / 8;
    localparam int SEL_W = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
    localparam int CNT_W = 4;

    bridge_state_t     state_q, state_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_dout_q, mem_dout_d;
`ifdef MEM_IO_BYTE_LANE_EN
    logic [BE_W-1:0]   be_q, be_d;
`endif

    logic              req_is_io;
    logic [DATA_W-1:0] io_rdata;
    logic [BE_W-1:0]   io_be;
    mem_strobe_t       strobe;

    assign req_is_io = is_io_addr(32'(bus.Addr), 32'(IO_BASE), NUM_IO);

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        mem_addr_d = mem_addr_q;
        mem_dout_d = mem_dout_q;
`ifdef MEM_IO_BYTE_LANE_EN
        be_d       = be_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.Req) begin
                    we_d    = bus.We;
                    wdata_d = bus.Wdata;
                    sel_d   = SEL_W'(bus.Addr - IO_BASE);
`ifdef MEM_IO_BYTE_LANE_EN
                    be_d    = bus.Be;
`endif
                    if (req_is_io) begin
                        state_d = IO;
                    end else begin
                        // Memory address/data are only updated by memory
                        // cycles so they hold across I/O accesses.
                        state_d    = SETUP;
                        mem_addr_d = bus.Addr;
                        if (bus.We) begin
                            mem_dout_d = bus.Wdata;
                        end
                    end
                end
            end
            IO: begin
                if (!we_q) begin
                    rdata_d = io_rdata;
                end
                state_d = DONE;
            end
            SETUP: begin
                cnt_d   = CNT_W'(WAIT_STATES);
                state_d = ACCESS;
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        rdata_d = Mem_Din;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            sel_q      <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            mem_addr_q <= '0;
            mem_dout_q <= '0;
`ifdef MEM_IO_BYTE_LANE_EN
            be_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            mem_addr_q <= mem_addr_d;
            mem_dout_q <= mem_dout_d;
`ifdef MEM_IO_BYTE_LANE_EN
            be_q       <= be_d;
`endif
        end
    end

    // Strobes decode straight from the registered state, so a reset edge
    // releases them on that same edge.
    always_comb begin
        strobe = STROBE_IDLE;
        if (state_q == SETUP || state_q == ACCESS) begin
            strobe.ce = 1'b0;
            if (state_q == ACCESS) begin
                strobe.oe = we_q;
                strobe.we = ~we_q;
            end
`ifdef MEM_IO_BYTE_LANE_EN
            strobe.ub = ~be_q[BE_W-1];
            strobe.lb = ~be_q[0];
`else
            strobe.ub = 1'b0;
            strobe.lb = 1'b0;
`endif
        end
    end

`ifdef MEM_IO_BYTE_LANE_EN
    assign io_be = be_q;
`else
    assign io_be = '1;
`endif

    mem_io_regs #(
        .DATA_W (DATA_W),
        .NUM_IO (NUM_IO),
        .SEL_W  (SEL_W)
    ) u_regs (
        .clk      (Clk),
        .rst      (Reset),
        .wr_en    ((state_q == IO) && we_q),
        .sel      (sel_q),
        .wdata    (wdata_q),
        .be       (io_be),
        .switches (Switches),
        .display  (Display),
        .rd_data  (io_rdata)
    );

    assign bus.Rdata = rdata_q;
    assign bus.Ack   = (state_q == DONE);
    assign bus.Busy  = (state_q != IDLE);
    assign Mem_Addr  = mem_addr_q;
    assign Mem_Dout  = mem_dout_q;
    assign Mem_CE    = strobe.ce;
    assign Mem_OE    = strobe.oe;
    assign Mem_WE    = strobe.we;
    assign Mem_UB    = strobe.ub;
    assign Mem_LB    = strobe.lb;

endmodule
